// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: sequencer/state holder for the radix-8 inverse AES round datapath; optional abort via AES_INV_ROUND_CTRL_ABORT_EN
module aes_inv_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [1:0]   in_mode,
    output logic [3:0]   key_req_round,
    input  logic         key_valid,
    output logic [3:0]   rd_round,
    output logic [1:0]   rd_mode,
    output logic [3:0]   rd_width_sel,
    output logic [127:0] rd_data_in,
    input  logic [127:0] rd_data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode_err,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t     state, state_d;
    logic [3:0] nr;
    logic       accept, beat, last_beat, abort_now;

    // reserved mode 11 runs with the AES-128 round count
    assign nr        = rd_mode == 2'b01 ? 4'd12 : rd_mode == 2'b10 ? 4'd14 : 4'd10;
    assign accept    = state == IDLE && in_valid;
    assign beat      = state == ROUND && (rd_width_sel != 4'd0 || key_valid);
    assign last_beat = beat && rd_width_sel == 4'd15;
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
    assign abort_now = abort && state != IDLE;
`else
    assign abort_now = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // next state and handshake/status outputs
    always_comb begin
        state_d       = state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b1;
        key_req_round = nr - rd_round;
        case (state)
            IDLE: begin
                in_ready      = 1'b1;
                busy          = 1'b0;
                key_req_round = 4'd0;
                if (in_valid) state_d = ROUND;
            end
            ROUND:   if (last_beat && rd_round + 4'd1 == nr) state_d = FINAL;
            FINAL:   if (key_valid) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_now) state_d = IDLE;
    end

    // round/lane counters, working state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_round     <= 4'd0;
            rd_width_sel <= 4'd0;
            rd_mode      <= 2'd0;
            rd_data_in   <= 128'd0;
            out_data     <= 128'd0;
            out_mode_err <= 1'b0;
        end else if (abort_now) begin
            rd_round     <= 4'd0;
            rd_width_sel <= 4'd0;
        end else begin
            if (accept) begin
                rd_data_in   <= in_data;
                rd_mode      <= in_mode;
                rd_round     <= 4'd0;
                rd_width_sel <= 4'd0;
                out_mode_err <= 1'b0;
            end
            if (beat) begin
                rd_width_sel <= rd_width_sel + 4'd1;
                if (rd_width_sel == 4'd15) begin
                    rd_data_in <= rd_data_out;
                    rd_round   <= rd_round + 4'd1;
                end
            end
            if (state == FINAL && key_valid) begin
                out_data     <= rd_data_out;
                out_mode_err <= rd_mode == 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl: randomized bench with a behavioural datapath/key-store and a round-level reference model
module tb_aes_inv_round_ctrl;
    logic         clk = 0, rst_n = 0, in_valid = 0, key_valid = 1, out_ready = 0, abort = 0;
    logic [127:0] in_data = '0;
    logic [1:0]   in_mode = '0, cur_mode = '0;
    logic         in_ready, out_valid, out_mode_err, busy;
    logic [3:0]   key_req_round, rd_round, rd_width_sel;
    logic [1:0]   rd_mode;
    logic [127:0] rd_data_in, rd_data_out, out_data;
    int           n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    aes_inv_round_ctrl dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .key_req_round(key_req_round), .key_valid(key_valid),
        .rd_round(rd_round), .rd_mode(rd_mode), .rd_width_sel(rd_width_sel),
        .rd_data_in(rd_data_in), .rd_data_out(rd_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode_err(out_mode_err), .busy(busy)
    );

    function automatic int nr_of(input logic [1:0] m);
        return m == 2'b01 ? 12 : m == 2'b10 ? 14 : 10;
    endfunction

    // stand-in round function: depends on state, requested key index and round number
    function automatic logic [127:0] dp_round(input logic [127:0] s, input int k, input int r);
        logic [31:0]  kw;
        logic [127:0] rw;
        kw = 32'h9e3779b9 * 32'(k + 1);
        rw = {32'd0, 32'(r), 64'd0};
        return {s[124:0], s[127:125]} ^ {4{kw}} ^ rw;
    endfunction

    // datapath output is only the true round result on the last lane of a round (or in the final round)
    assign rd_data_out = dp_round(rd_data_in, int'(key_req_round), int'(rd_round)) ^
                         ((int'(rd_round) == nr_of(cur_mode)) ? 128'd0 : {124'd0, ~rd_width_sel});

    function automatic logic [127:0] model_rounds(input logic [127:0] ct, input logic [1:0] md, input int n);
        logic [127:0] s;
        s = ct;
        for (int r = 0; r < n; r++) s = dp_round(s, nr_of(md) - r, r);
        return s;
    endfunction

    function automatic logic [127:0] model_full(input logic [127:0] ct, input logic [1:0] md);
        return dp_round(model_rounds(ct, md, nr_of(md)), 0, nr_of(md));
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // key_valid for cycle c after acceptance: stall windows forced low, beat-0 cycles high, others optionally noisy
    function automatic logic kv_at(input int c, input int nr, input int sr, input int len, input int fs, input bit noise);
        int base, f;
        base = 1 + 16 * sr;
        f    = 1 + 16 * nr + len;
        if (c >= base && c < base + len) return 1'b0;
        if (c >= f && c < f + fs) return 1'b0;
        if (c >= f) return 1'b1;
        if (c < base) return ((c - 1) % 16 == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b1);
        return ((c - len - 1) % 16 == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b1);
    endfunction

    task automatic accept_block(input logic [127:0] ct, input logic [1:0] md);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        cur_mode = md;
        in_data  = ct;
        in_mode  = md;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        in_data  = {4{$urandom}};
        in_mode  = 2'($urandom);
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [1:0] md, input int sr, input int len,
                             input int fs, input int bp, input bit noise);
        int nr, base, f, er, lat;
        logic [127:0] exp;
        bit stable;
        nr   = nr_of(md);
        exp  = model_full(ct, md);
        base = 1 + 16 * sr;
        f    = 1 + 16 * nr + len;
        lat  = -1;
        accept_block(ct, md);
        for (int c = 1; c <= 16 * nr + 10 + len + fs; c++) begin
            key_valid = kv_at(c, nr, sr, len, fs, noise);
            @(negedge clk);
            er = -1;
            if (c >= base && c < base + len) er = sr;
            else if (c < base && (c - 1) % 16 == 0) er = (c - 1) / 16;
            else if (c >= base + len && c < f && (c - len - 1) % 16 == 0) er = (c - len - 1) / 16;
            if (er >= 0) begin
                check("wsel_beat0", rd_width_sel, 0);
                check("round", rd_round, er);
                check("key_req_round", key_req_round, nr - er);
            end
            if (c == f) begin
                check("final_round", rd_round, nr);
                check("final_key_req", key_req_round, 0);
                check("final_wsel", rd_width_sel, 0);
            end
            if (c == 2) check("in_ready_busy", {in_ready, busy}, 2'b01);
            if (out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        key_valid = 1;
        check("latency", lat, 16 * nr + 2 + len + fs);
        if (lat < 0) return;
        check("out_data", out_data, exp);
        check("out_mode_err", out_mode_err, md == 2'b11);
        check("done_in_ready", in_ready, 0);
        stable = 1;
        repeat (bp) begin
            @(negedge clk);
            stable &= (out_data === exp) && out_valid && !in_ready;
        end
        check("backpressure_stable", stable, 1);
        @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        check("released", {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] ct;
        logic [1:0]   md;
        bit           seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {in_ready, out_valid, busy, out_mode_err}, 4'b1000);
        check("rst_round", rd_round, 0);
        check("rst_wsel", rd_width_sel, 0);
        check("rst_mode", rd_mode, 0);
        check("rst_data_in", rd_data_in, 0);
        check("rst_out_data", out_data, 0);
        check("rst_key_req", key_req_round, 0);
        rst_n = 1;

        // directed: key stall at beat 0 of round 3 plus backpressure, then longest mode, then reserved mode
        run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'b00, 3, 5, 0, 10, 0);
        run_block(128'h8ea2b7ca516745bfeafc49904b496089, 2'b10, 0, 0, 0, 0, 0);
        run_block(128'h0123456789abcdeffedcba9876543210, 2'b11, 0, 0, 2, 3, 1);

        // randomized blocks
        for (int i = 0; i < 8; i++) begin
            ct = {$urandom, $urandom, $urandom, $urandom};
            md = 2'($urandom_range(0, 3));
            run_block(ct, md, $urandom_range(0, nr_of(md) - 1), $urandom_range(0, 6),
                      $urandom_range(0, 3), $urandom_range(0, 10), 1);
        end

        // mid-operation reset discards the block
        accept_block(128'hdeadbeef_00000000_cafef00d_12345678, 2'b00);
        repeat (16 * 5 + 2) @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("midrst_flags", {in_ready, out_valid, busy}, 3'b100);
        check("midrst_round", rd_round, 0);
        check("midrst_data_in", rd_data_in, 0);
        @(posedge clk);
        #1 rst_n = 1;
        seen = 0;
        repeat (250) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("midrst_no_output", seen, 0);
        run_block({$urandom, $urandom, $urandom, $urandom}, 2'b01, 4, 2, 1, 2, 1);

`ifdef AES_INV_ROUND_CTRL_ABORT_EN
        // abort at round 2 beat 7
        ct = {$urandom, $urandom, $urandom, $urandom};
        md = 2'($urandom_range(0, 2));
        accept_block(ct, md);
        repeat (39) @(posedge clk);
        #1 abort = 1;
        @(negedge clk);
        check("abort_pos", {rd_round, rd_width_sel}, {4'd2, 4'd7});
        @(posedge clk);
        #1 abort = 0;
        @(negedge clk);
        check("abort_flags", {in_ready, out_valid, busy}, 3'b100);
        check("abort_counters", {rd_round, rd_width_sel}, 8'd0);
        check("abort_data_kept", rd_data_in, model_rounds(ct, md, 2));
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_output", seen, 0);
        run_block({$urandom, $urandom, $urandom, $urandom}, md, 1, 3, 0, 1, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
Sequencer and state holder for the radix-8 inverse AES round datapath (aes_inv_rounddata).
- Accepts a 128-bit ciphertext block over a valid/ready handshake.
- Drives round number, mode and byte-lane select (width_sel) to the round datapath.
- Requests round keys from the key store in reverse order.
- Feeds each round's result back as the next round's input and presents the plaintext over a valid/ready output handshake.

Parameters:
- None. Round counts are fixed by mode: 10, 12 or 14.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext block valid
- in_ready  out  1  block can be accepted
- in_data  in  128  ciphertext
- in_mode  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
- key_req_round  out  4  round-key index requested (Nr - round)
- key_valid  in  1  requested round key present on datapath round_key
- rd_round  out  4  round number to datapath
- rd_mode  out  2  latched mode to datapath
- rd_width_sel  out  4  byte lane 0..15 within current round
- rd_data_in  out  128  state register driven to datapath data_in
- rd_data_out  in  128  datapath data_out
- out_valid  out  1  plaintext valid
- out_ready  in  1  downstream accepts plaintext
- out_data  out  128  plaintext
- out_mode_err  out  1  block was submitted with mode 11
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - in_ready=1, out_valid=0, busy=0, out_mode_err=0.
  - rd_round=0, rd_width_sel=0, rd_mode=0, rd_data_in=0, out_data=0, key_req_round=0.
- Asserting rst_n mid-operation discards the block and returns to IDLE; no output is produced.
- Nr = 10, 12 or 14 for mode 00, 01 or 10.
  - Mode 11: processed as AES-128; out_mode_err=1 returned with that block's out_valid; cleared on the next acceptance.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into rd_data_in and in_mode into rd_mode; round=0, width_sel=0; go to ROUND.
- ROUND (round 0..Nr-1):
  - rd_width_sel advances 0..15, one per cycle.
  - Beat 0 stall: if key_valid=0 at beat 0, width_sel holds at 0 and no beat counts. key_valid is ignored on beats 1..15 (key held stable per round by the key store).
  - Beat 15: rd_data_in <= rd_data_out, round increments, width_sel wraps to 0.
  - If the new round == Nr, go to FINAL.
- FINAL (round=Nr, addroundkey only):
  - Waits for key_valid, then in that cycle out_data <= rd_data_out; go to DONE.
  - rd_width_sel=0.
- DONE:
  - out_valid=1; out_data and out_mode_err held stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
  - in_ready=0 in DONE; no same-cycle accept on the output handshake.
- key_req_round = Nr - round, combinational from the latched mode and round counter; valid in all non-IDLE states.
- Latency with key_valid held 1: accept at cycle T gives out_valid at T + 16*Nr + 2.
  - AES-128: T+162. AES-192: T+194. AES-256: T+226.
- in_ready=0 in ROUND, FINAL and DONE; in_valid is ignored there, and in_data/in_mode changes have no effect.
- width_sel is 4-bit and wraps 15->0 naturally. The round counter never exceeds 14.

Optional Feature:
- Macro AES_INV_ROUND_CTRL_ABORT_EN.
- When defined: adds input `abort` (1 bit). abort=1 in any non-IDLE state returns the FSM to IDLE on the next edge.
  - out_valid forced 0; round and width_sel cleared; rd_data_in retained; no output produced.
  - abort in IDLE has no effect. If abort and in_valid are both high in IDLE, the block is accepted.
- When not defined: no abort port; behaviour exactly as above.

Test Plan:
- Reset and idle: rst_n low for 3 cycles -> in_ready=1, out_valid=0, busy=0, all outputs 0.
- FIPS-197 AES-128 known answer (datapath and key store in bench, key 000102..0f, key_valid=1): in_data=69c4e0d86a7b0430d8cdb78070b4c55a, mode 00 accepted at T -> out_valid at T+162, out_data=00112233445566778899aabbccddeeff.
- AES-256 known answer: key 000102..1f, in_data=8ea2b7ca516745bfeafc49904b496089, mode 10 -> out_data=00112233445566778899aabbccddeeff at T+226; key_req_round sequence 14,13,...,0.
- Key stall and backpressure: key_valid=0 for 5 cycles at beat 0 of round 3 -> width_sel holds 0 and out_valid is delayed exactly 5 cycles. Then out_ready=0 for 10 cycles -> out_data stable, in_ready=0.
- Mode 11 and mid-operation reset: mode 11 block -> AES-128 timing with out_mode_err=1. Separately, rst_n pulsed low at round 5 -> immediate IDLE, no out_valid; next block completes correctly.
- With AES_INV_ROUND_CTRL_ABORT_EN: abort at round 2 beat 7 -> IDLE next cycle, no out_valid. A new block accepted afterwards gives a correct result.
